mem_bus_arbiter: RTL

- Parametrised N-master byte-wide memory/IO bus arbiter and address decoder. It replaces the fixed two-way CPU/debug mux in the top level.
- Arbitrates NUM_MASTERS request/grant ports, using either fixed-priority or round-robin mode. Supports multi-cycle bus lock.
- Decodes each granted access to internal RAM or the memory-mapped IO block, and stalls IO writes while the IO buffer is full.
- Routes the one-cycle-latency read data back to the issuing master, using a registered return tag.

---
 rtl/mem_bus_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// N-master byte bus arbiter with RAM/IO decode and tagged one-cycle read return.
// Optional lock watchdog compiled in with `define MEM_ARB_WATCHDOG_EN.
//
//   state    | meaning
//   S_IDLE   | no lock held; winner picked by fixed priority or round-robin
//   S_LOCKED | owner_q holds the bus; only the owner may be granted
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int ARB_MODE       = 0,
  parameter int LOCK_MAX       = 64
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_MASTERS-1:0]      m_req_in,
  input  logic [NUM_MASTERS-1:0]      m_lock_in,
  input  logic [32*NUM_MASTERS-1:0]   m_a_in,
  input  logic [NUM_MASTERS-1:0]      m_wr_in,
  input  logic [8*NUM_MASTERS-1:0]    m_dout_in,
  output logic [NUM_MASTERS-1:0]      m_gnt_out,
  output logic [NUM_MASTERS-1:0]      m_rvalid_out,
  output logic [7:0]                  m_din_out,
  output logic                        ram_en_out,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_a_out,
  output logic                        ram_wr_out,
  output logic [7:0]                  ram_d_out,
  input  logic [7:0]                  ram_d_in,
  output logic                        io_en_out,
  output logic [2:0]                  io_sel_out,
  output logic                        io_wr_out,
  output logic [7:0]                  io_d_out,
  input  logic [7:0]                  io_d_in,
  input  logic                        io_full_in,
  output logic [2:0]                  owner_out,
  output logic                        wdog_err_out
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d, rr_q, rr_d;
  logic       tag_vld_q, tag_io_q;
  logic [2:0] tag_mst_q;

  logic [7:0]   req8, lock8, wr8;
  logic [255:0] a_pad;
  logic [63:0]  d_pad;
  logic         arb_found, cand_found;
  logic [2:0]   arb_idx, cand_idx;
  logic [RAM_ADDR_WIDTH:0] cand_a;
  logic [7:0]   cand_d;
  logic         cand_io, cand_wr, blocked, gnt_any, wdog_expire;
  logic [7:0]   gnt8, rvld8;

  // Pad per-master vectors to the 8-master maximum so 3-bit indices are always in range.
  assign req8  = 8'(m_req_in);
  assign lock8 = 8'(m_lock_in);
  assign wr8   = 8'(m_wr_in);
  assign a_pad = 256'(m_a_in);
  assign d_pad = 64'(m_dout_in);

  // Descending scan so the lowest offset from the start point is assigned last and wins.
  always_comb begin
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      j = (ARB_MODE == 1) ? (int'(rr_q) + i) % NUM_MASTERS : i;
      if (req8[j]) begin
        arb_found = 1'b1;
        arb_idx   = 3'(j);
      end
    end
  end

  // A requesting owner keeps the bus even on its release cycle; an idle owner
  // still holding lock blocks everyone, and an idle releasing owner falls through.
  always_comb begin
    cand_found = arb_found;
    cand_idx   = arb_idx;
    if (state_q == S_LOCKED) begin
      if (req8[owner_q]) begin
        cand_found = 1'b1;
        cand_idx   = owner_q;
      end else if (lock8[owner_q]) begin
        cand_found = 1'b0;
        cand_idx   = owner_q;
      end
    end
  end

  assign cand_a  = a_pad[int'(cand_idx)*32 +: RAM_ADDR_WIDTH+1];
  assign cand_d  = d_pad[int'(cand_idx)*8 +: 8];
  assign cand_io = (cand_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign cand_wr = wr8[cand_idx];
  assign blocked = cand_found & cand_io & cand_wr & io_full_in;
  assign gnt_any = cand_found & ~blocked & rst_n_in;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(LOCK_MAX + 1);
  logic [WD_W-1:0] wdog_cnt_q;
  logic            wdog_err_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wdog_cnt_q <= WD_W'(LOCK_MAX - 1);
      wdog_err_q <= 1'b0;
    end else begin
      if (state_q != S_LOCKED)
        wdog_cnt_q <= WD_W'(LOCK_MAX - 1);
      else if (wdog_cnt_q != '0)
        wdog_cnt_q <= wdog_cnt_q - 1'b1;
      if (wdog_expire)
        wdog_err_q <= 1'b1;
    end
  end

  assign wdog_expire  = (state_q == S_LOCKED) && (wdog_cnt_q == '0);
  assign wdog_err_out = wdog_err_q;
`else
  assign wdog_expire  = 1'b0;
  assign wdog_err_out = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      tag_vld_q <= 1'b0;
      tag_mst_q <= '0;
      tag_io_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      tag_vld_q <= gnt_any & ~cand_wr;
      if (gnt_any) begin
        tag_mst_q <= cand_idx;
        tag_io_q  <= cand_io;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    if (gnt_any) begin
      owner_d = cand_idx;
      if (ARB_MODE == 1)
        rr_d = 3'((int'(cand_idx) + 1) % NUM_MASTERS);
      state_d = lock8[cand_idx] ? S_LOCKED : S_IDLE;
    end else if (state_q == S_LOCKED && !blocked && !lock8[owner_q]) begin
      state_d = S_IDLE;
    end
    if (wdog_expire)
      state_d = S_IDLE;
  end

  always_comb begin
    gnt8         = gnt_any ? (8'd1 << cand_idx) : 8'd0;
    rvld8        = tag_vld_q ? (8'd1 << tag_mst_q) : 8'd0;
    m_gnt_out    = gnt8[NUM_MASTERS-1:0];
    m_rvalid_out = rvld8[NUM_MASTERS-1:0];
    m_din_out    = tag_vld_q ? (tag_io_q ? io_d_in : ram_d_in) : 8'h00;
    ram_en_out   = gnt_any & ~cand_io;
    ram_wr_out   = gnt_any & ~cand_io & cand_wr;
    ram_a_out    = (gnt_any && !cand_io) ? cand_a[RAM_ADDR_WIDTH-1:0] : '0;
    ram_d_out    = (gnt_any && !cand_io) ? cand_d : 8'h00;
    io_en_out    = gnt_any & cand_io;
    io_wr_out    = gnt_any & cand_io & cand_wr;
    io_sel_out   = (gnt_any && cand_io) ? cand_a[2:0] : 3'd0;
    io_d_out     = (gnt_any && cand_io) ? cand_d : 8'h00;
    owner_out    = gnt_any ? cand_idx : owner_q;
  end

endmodule
